// File: rtl/uart_single_frame_rx.sv
// uart_single_frame_rx
// Receives one UART frame at a time from the asynchronous line rx and
// presents the received byte on data with a one-cycle valid pulse. Framing
// and parity problems are reported as one-cycle error pulses and never
// delivered as valid data.
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity bit
// between the data bits and the stop bit). Without it the frame is 8N1 and
// parity_err is constant 0.
module uart_single_frame_rx #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int          CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
   localparam logic [13:0] BIT_LAST     = 14'(CLKS_PER_BIT - 1);
   localparam logic [13:0] HALF_LAST    = 14'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t      state;
   logic [13:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;

   // Synchronizer chain and falling-edge history; all reset to 0 so a line
   // that is already low when reset releases never looks like a start bit.
   logic        rx_meta;
   logic        rx_s;
   logic        rx_d;
   logic        fall_p0;

   // Even-parity mismatch: data bits plus parity bit must XOR to 0.
   logic        mismatch;

`ifdef UART_RX_PARITY_EN
   logic        par_bit;

   function automatic logic parity_mismatch(input logic [7:0] d,
                                            input logic       p);
      return (^d) ^ p;
   endfunction

   assign mismatch = parity_mismatch(shift, par_bit);
`else
   assign mismatch   = 1'b0;
   assign parity_err = 1'b0;
`endif

   // Two-flop synchronizer, history flop and registered falling-edge detect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b0;
         rx_s    <= 1'b0;
         rx_d    <= 1'b0;
         fall_p0 <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
         fall_p0 <= rx_d & ~rx_s;
      end
   end

   // Data shift register: captures each data bit at its mid-bit sample point.
   always_ff @(posedge clk) begin
      if (state == S_DATA && cnt == BIT_LAST) begin
         shift[bit_idx] <= rx_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity bit capture at the mid-bit sample point of the parity slot.
   always_ff @(posedge clk) begin
      if (state == S_PARITY && cnt == BIT_LAST) begin
         par_bit <= rx_s;
      end
   end
`endif

   // Frame FSM with registered outputs; pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= 14'd0;
         bit_idx    <= 3'd0;
         data       <= 8'h00;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         busy       <= 1'b0;
      end else begin
         valid      <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               cnt <= 14'd0;
               if (fall_p0) begin
                  state <= S_START;
                  busy  <= 1'b1;
               end
            end

            // Wait half a bit and confirm the line is still low.
            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= 14'd0;
                  bit_idx <= 3'd0;
                  if (!rx_s) begin
                     state <= S_DATA;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 14'd1;
               end
            end

            S_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= 14'd0;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 14'd1;
               end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= 14'd0;
                  state <= S_STOP;
               end else begin
                  cnt <= cnt + 14'd1;
               end
            end
`endif

            // The byte is always published; the pulses say whether to trust it.
            S_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt       <= 14'd0;
                  data      <= shift;
                  frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                  parity_err <= mismatch;
`endif
                  valid     <= rx_s & ~mismatch;
                  if (rx_s) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_BREAK;
                  end
               end else begin
                  cnt <= cnt + 14'd1;
               end
            end

            // Low stop bit: wait for the line to go idle before rearming.
            S_BREAK: begin
               cnt <= 14'd0;
               if (rx_s) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= S_IDLE;
               cnt   <= 14'd0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_single_frame_rx.sv
// Directed testbench for uart_single_frame_rx. The DUT runs with a reduced
// clock/baud ratio (32 clocks per bit) so that all frames fit in a short
// run; every expected time is derived from that ratio. Long idle/low holds
// are scaled down accordingly.
module tb_uart_single_frame_rx;

   localparam int CFREQ = 3_200_000;
   localparam int BAUD  = 100_000;
   localparam int C     = CFREQ / BAUD;   // 32 clocks per bit
   localparam int H     = C / 2;          // 16
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // Stop sample edge relative to E0.
   localparam int STOP_OFS = 3 + H + (NBITS - 1) * C;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   uart_single_frame_rx #(
      .CLOCK_FREQ(CFREQ),
      .BAUD_RATE (BAUD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse / busy-edge recorder, sampled on the falling edge.
   int         n_valid = 0, n_ferr = 0, n_perr = 0, n_rise = 0, n_excl = 0;
   int         perr_total = 0;
   int         valid_cyc = -1, ferr_cyc = -1, perr_cyc = -1;
   int         rise_cyc = -1, fall_cyc = -1;
   logic [7:0] valid_data = 8'h00;
   logic       busy_q = 1'b0;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         n_valid++;
         valid_cyc  = cyc;
         valid_data = data;
      end
      if (frame_err === 1'b1) begin
         n_ferr++;
         ferr_cyc = cyc;
      end
      if (parity_err === 1'b1) begin
         n_perr++;
         perr_total++;
         perr_cyc = cyc;
      end
      if (valid === 1'b1 && (frame_err === 1'b1 || parity_err === 1'b1)) n_excl++;
      if (busy === 1'b1 && busy_q === 1'b0) begin
         n_rise++;
         rise_cyc = cyc;
      end
      if (busy === 1'b0 && busy_q === 1'b1) fall_cyc = cyc;
      busy_q = busy;
   end

   int errors = 0;
   int checks = 0;

`ifdef UART_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_valid = 0; n_ferr = 0; n_perr = 0; n_rise = 0;
      valid_cyc = -1; ferr_cyc = -1; perr_cyc = -1;
      rise_cyc = -1; fall_cyc = -1;
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (C) @(negedge clk);
   endtask

   // Called at (or just after) a falling edge; E0 is the next rising edge.
   task automatic send(input logic [7:0] b, input logic stop_v, output int e0);
      e0 = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
`endif
      drive_bit(stop_v);
   endtask

   int e0;

   initial begin
      // Reset with the line held low.
      rst_n = 1'b0;
      rx    = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("rst_data",  32'(data), 32'h00);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_ferr",  32'(frame_err), 32'd0);
      check("rst_perr",  32'(parity_err), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      clr();
      rst_n = 1'b1;
      repeat (2000) @(negedge clk);
      #1;
      check("low_busy",  32'(busy), 32'd0);
      check("low_rise",  32'(n_rise), 32'd0);
      check("low_valid", 32'(n_valid), 32'd0);
      check("low_ferr",  32'(n_ferr), 32'd0);

      // Line goes idle; no start may be seen on the rising edge.
      rx = 1'b1;
      repeat (4 * C) @(negedge clk);
      #1;
      check("idle_rise", 32'(n_rise), 32'd0);

      // Single good frame 8'hA5.
      clr();
      send(8'hA5, 1'b1, e0);
      #1;
      check("a5_nvalid",   32'(n_valid), 32'd1);
      check("a5_vcyc",     32'(valid_cyc), 32'(e0 + STOP_OFS));
      check("a5_vdata",    32'(valid_data), 32'hA5);
      check("a5_data",     32'(data), 32'hA5);
      check("a5_ferr",     32'(n_ferr), 32'd0);
      check("a5_perr",     32'(n_perr), 32'd0);
      check("a5_rise",     32'(rise_cyc), 32'(e0 + 3));
      check("a5_fall",     32'(fall_cyc), 32'(e0 + STOP_OFS));
      check("a5_busy",     32'(busy), 32'd0);

      // False start: short low glitch.
      repeat (2 * C) @(negedge clk);
      clr();
      e0 = cyc + 1;
      rx = 1'b0;
      repeat (6) @(negedge clk);
      rx = 1'b1;
      repeat (3 * C) @(negedge clk);
      #1;
      check("fs_rise",   32'(rise_cyc), 32'(e0 + 3));
      check("fs_fall",   32'(fall_cyc), 32'(e0 + 3 + H));
      check("fs_valid",  32'(n_valid), 32'd0);
      check("fs_ferr",   32'(n_ferr), 32'd0);
      check("fs_busy",   32'(busy), 32'd0);

      // Framing error: 8'h3C with a low stop bit, then line held low.
      clr();
      send(8'h3C, 1'b0, e0);
      repeat (1000) @(negedge clk);
      #1;
      check("fe_nferr",  32'(n_ferr), 32'd1);
      check("fe_fcyc",   32'(ferr_cyc), 32'(e0 + STOP_OFS));
      check("fe_valid",  32'(n_valid), 32'd0);
      check("fe_data",   32'(data), 32'h3C);
      check("fe_busy",   32'(busy), 32'd1);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("fe_idle",   32'(busy), 32'd0);
      check("fe_nferr2", 32'(n_ferr), 32'd1);

      // Back-to-back frames, then reset in the middle of a fourth.
      repeat (2 * C) @(negedge clk);
      clr();
      send(8'h00, 1'b1, e0);
      #1;
      check("bb0_n",    32'(n_valid), 32'd1);
      check("bb0_data", 32'(valid_data), 32'h00);
      check("bb0_cyc",  32'(valid_cyc), 32'(e0 + STOP_OFS));
      send(8'hFF, 1'b1, e0);
      #1;
      check("bb1_n",    32'(n_valid), 32'd2);
      check("bb1_data", 32'(valid_data), 32'hFF);
      check("bb1_cyc",  32'(valid_cyc), 32'(e0 + STOP_OFS));
      send(8'h55, 1'b1, e0);
      #1;
      check("bb2_n",    32'(n_valid), 32'd3);
      check("bb2_data", 32'(valid_data), 32'h55);
      check("bb2_cyc",  32'(valid_cyc), 32'(e0 + STOP_OFS));
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rx    = 1'b1;
      repeat (2 * NBITS * C) @(negedge clk);
      #1;
      check("ab_n",     32'(n_valid), 32'd3);
      check("ab_ferr",  32'(n_ferr), 32'd0);
      check("ab_busy",  32'(busy), 32'd0);
      check("ab_data",  32'(data), 32'h00);

`ifdef UART_RX_PARITY_EN
      // 8'h07 with correct even parity bit (1).
      clr();
      par_flip = 1'b0;
      send(8'h07, 1'b1, e0);
      #1;
      check("p1_valid", 32'(n_valid), 32'd1);
      check("p1_vcyc",  32'(valid_cyc), 32'(e0 + STOP_OFS));
      check("p1_data",  32'(valid_data), 32'h07);
      check("p1_perr",  32'(n_perr), 32'd0);
      // 8'h07 with a wrong parity bit (0).
      clr();
      par_flip = 1'b1;
      send(8'h07, 1'b1, e0);
      #1;
      par_flip = 1'b0;
      check("p0_perr",  32'(n_perr), 32'd1);
      check("p0_pcyc",  32'(perr_cyc), 32'(e0 + STOP_OFS));
      check("p0_valid", 32'(n_valid), 32'd0);
      check("p0_ferr",  32'(n_ferr), 32'd0);
      check("p0_data",  32'(data), 32'h07);
`else
      check("np_perr",  32'(perr_total), 32'd0);
`endif

      check("excl", 32'(n_excl), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
